// File: rtl/mul32_iter_ctrl.sv
// mul32_iter_ctrl: signed W x W multiply with one shared 8x8 multiplier, one byte pair per cycle.
// Latency: out_valid rises N_CHUNK^2+2 edges after the input handshake (18 edges for N_CHUNK=4).
// Backpressure: in_ready is high only in IDLE. Product and out_valid hold in DONE until out_ready.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready + A/B operand handshake;
//        out_valid/out_ready + Product result handshake; busy = not IDLE.
// Optional build macro MUL_UNSIGNED_EN adds the is_signed input. It is sampled with A/B.
// When is_signed=0 the operands are treated as unsigned.

module wallace_mul_8bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    // The partial-product rows are summed here. Synthesis reduces the sum to a compressor tree.
    always_comb begin
        p = '0;
        for (int r = 0; r < 8; r++) begin
            if (b[r]) p = p + ({8'b0, a} << r);
        end
    end
endmodule

module mul32_iter_ctrl #(
    parameter int N_CHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*N_CHUNK-1:0]   A,
    input  logic [8*N_CHUNK-1:0]   B,
`ifdef MUL_UNSIGNED_EN
    input  logic                   is_signed,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [16*N_CHUNK-1:0]  Product,
    output logic                   busy
);
    localparam int W     = 8 * N_CHUNK;
    localparam int PW    = 2 * W;
    localparam int NSTEP = N_CHUNK * N_CHUNK;
    localparam int KW    = $clog2(NSTEP + 1);
    localparam int IW    = $clog2(N_CHUNK + 1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_MUL, S_FIX, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_q, b_q;
    logic           neg_q;
    logic           abs_q;      // 1: convert operands to magnitudes in PREP
    logic [PW-1:0]  acc_q;
    logic [PW-1:0]  prod_q;
    logic [KW-1:0]  k_q;
    logic [IW-1:0]  i_q, j_q;   // byte indices that track k / N_CHUNK and k % N_CHUNK

    logic           in_signed;
    logic [7:0]     a_byte, b_byte;
    logic [15:0]    pp;
    logic [PW-1:0]  pp_shifted;
    logic           last_step;

`ifdef MUL_UNSIGNED_EN
    assign in_signed = is_signed;
`else
    assign in_signed = 1'b1;
`endif

    // Byte selection is built as a mux over constant slices.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int c = 0; c < N_CHUNK; c++) begin
            if (i_q == IW'(c)) a_byte = a_q[8*c +: 8];
            if (j_q == IW'(c)) b_byte = b_q[8*c +: 8];
        end
    end

    wallace_mul_8bit u_mul8 (
        .a (a_byte),
        .b (b_byte),
        .p (pp)
    );

    always_comb begin
        pp_shifted = PW'(pp) << (8 * (int'(i_q) + int'(j_q)));
    end

    assign last_step = (k_q == KW'(NSTEP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = S_PREP;
            end
            S_PREP: state_nxt = S_MUL;
            S_MUL:  if (last_step) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            abs_q  <= 1'b0;
            acc_q  <= '0;
            prod_q <= '0;
            k_q    <= '0;
            i_q    <= '0;
            j_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= A;
                        b_q   <= B;
                        abs_q <= in_signed;
                        neg_q <= in_signed & (A[W-1] ^ B[W-1]);
                    end
                end
                S_PREP: begin
                    // The negation is unsigned, so the most negative value maps to its own magnitude.
                    if (abs_q && a_q[W-1]) a_q <= -a_q;
                    if (abs_q && b_q[W-1]) b_q <= -b_q;
                    acc_q <= '0;
                    k_q   <= '0;
                    i_q   <= '0;
                    j_q   <= '0;
                end
                S_MUL: begin
                    acc_q <= acc_q + pp_shifted;
                    k_q   <= k_q + 1'b1;
                    if (j_q == IW'(N_CHUNK - 1)) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                S_FIX: prod_q <= neg_q ? -acc_q : acc_q;
                default: ;
            endcase
        end
    end

    assign Product = prod_q;

endmodule

// File: tb/tb_mul32_iter_ctrl.sv
module tb_mul32_iter_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] Product;
    logic        busy;
`ifdef MUL_UNSIGNED_EN
    logic        is_signed;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mul32_iter_ctrl #(.N_CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
`ifdef MUL_UNSIGNED_EN
        .is_signed (is_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Product   (Product),
        .busy      (busy)
    );

    // Reference model: plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Issues one operation. It returns the number of edges from the handshake until out_valid is seen.
    // It returns -1 on a timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                          output int lat, output logic [63:0] prod);
        int w;
        lat  = -1;
        prod = 'x;
        w    = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) return;
        A = a; B = b; in_valid = 1'b1;
`ifdef MUL_UNSIGNED_EN
        is_signed = sgn;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat  = c;
                prod = Product;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (Product !== 64'h0)  begin n_fail++; $display("FAIL reset_product got=%h exp=0", Product); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset in_ready=%b busy=%b exp 1/0", in_ready, busy);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta [5] = '{32'd3, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] tb [5] = '{32'hFFFFFFFB, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h87654321};
        logic [63:0] te [5] = '{64'hFFFFFFFFFFFFFFF1, 64'h4000000000000000, 64'h3FFFFFFF00000001,
                                64'h0000000000000001, 64'h0};
        int lat;
        logic [63:0] p;
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            run_op(ta[t], tb[t], 1'b1, lat, p);
            n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=18", t, lat); end
            n_checks++; if (p !== te[t]) begin n_fail++; $display("FAIL dir%0d_product got=%h exp=%h", t, p, te[t]); end
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d_back_to_idle out_valid=%b in_ready=%b exp 0/1", t, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random;
        int lat;
        logic [63:0] p, e;
        logic [31:0] a, b;
        for (int t = 0; t < 20; t++) begin
            a = $urandom;
            b = $urandom;
            if (t % 5 == 1) a[31] = 1'b1;
            if (t % 5 == 2) b = -b;
            e = ref_mul(a, b, 1'b1);
            out_ready = 1'b0;
            run_op(a, b, 1'b1, lat, p);
            n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=18", t, lat); end
            n_checks++; if (p !== e) begin n_fail++; $display("FAIL rnd%0d_product a=%h b=%h got=%h exp=%h", t, a, b, p, e); end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b1 || Product !== e) begin
                n_fail++; $display("FAIL rnd%0d_hold out_valid=%b product=%h exp 1/%h", t, out_valid, Product, e);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_release got=%b exp=0", t, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [31:0] a, b;
        logic [63:0] e;
        int lat;
        int bad_hold;
        int bad_ready;
        a = $urandom | 32'h80000000;
        b = $urandom;
        e = ref_mul(a, b, 1'b1);
        out_ready = 1'b0;
        bad_ready = 0;
        lat = -1;
        A = a; B = b; in_valid = 1'b1;
`ifdef MUL_UNSIGNED_EN
        is_signed = 1'b1;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            if (c >= 4 && c <= 8) begin
                A = $urandom; B = $urandom; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (c >= 4 && c <= 8 && in_ready !== 1'b0) bad_ready++;
            if (out_valid) lat = c;
        end
        in_valid = 1'b0;
        n_checks++; if (bad_ready != 0) begin n_fail++; $display("FAIL bp_in_ready_low bad_cycles=%0d exp=0", bad_ready); end
        n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL bp_latency got=%0d exp=18", lat); end
        n_checks++; if (Product !== e) begin n_fail++; $display("FAIL bp_product got=%h exp=%h", Product, e); end
        bad_hold = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || Product !== e) bad_hold++;
        end
        n_checks++; if (bad_hold != 0) begin n_fail++; $display("FAIL bp_stable bad_cycles=%0d exp=0", bad_hold); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b exp=0", out_valid); end
        n_checks++; if (Product !== e) begin n_fail++; $display("FAIL bp_product_after got=%h exp=%h", Product, e); end
    endtask

    task automatic test_async_reset;
        int lat;
        logic [63:0] p;
        out_ready = 1'b1;
        A = 32'h11112222; B = 32'h33334444; in_valid = 1'b1;
`ifdef MUL_UNSIGNED_EN
        is_signed = 1'b1;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ar_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL ar_busy got=%b exp=0", busy); end
        n_checks++; if (Product !== 64'h0)  begin n_fail++; $display("FAIL ar_product got=%h exp=0", Product); end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'h0, 32'h12345678, 1'b1, lat, p);
        n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL ar_new_latency got=%0d exp=18", lat); end
        n_checks++; if (p !== 64'h0) begin n_fail++; $display("FAIL ar_new_product got=%h exp=0", p); end
        @(posedge clk); #1;
    endtask

`ifdef MUL_UNSIGNED_EN
    task automatic test_unsigned;
        int lat;
        logic [63:0] p, e;
        logic [31:0] a, b;
        out_ready = 1'b1;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, p);
        n_checks++; if (p !== 64'hFFFFFFFE00000001) begin n_fail++; $display("FAIL uns_ff_product got=%h exp=fffffffe00000001", p); end
        n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL uns_latency got=%0d exp=18", lat); end
        @(posedge clk); #1;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, p);
        n_checks++; if (p !== 64'h1) begin n_fail++; $display("FAIL sgn_ff_product got=%h exp=1", p); end
        @(posedge clk); #1;
        for (int t = 0; t < 8; t++) begin
            a = $urandom; b = $urandom;
            e = ref_mul(a, b, 1'b0);
            run_op(a, b, 1'b0, lat, p);
            n_checks++; if (p !== e) begin n_fail++; $display("FAIL uns_rnd%0d got=%h exp=%h", t, p, e); end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
`ifdef MUL_UNSIGNED_EN
        is_signed = 1'b1;
`endif
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_async_reset();
`ifdef MUL_UNSIGNED_EN
        test_unsigned();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
